// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state encodings and requester IDs.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_select.sv
// Combinational winner pick between the CPU and debug requesters.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise the CPU port has fixed priority.
module dmem_arb_select
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_RR_EN
  input  logic last_winner,
`endif
  output logic grant_valid,
  output logic winner
);

  always_comb begin
    grant_valid = req0 | req1;
`ifdef DMEM_ARB_RR_EN
    // On a tie, the port that did not win last time goes next.
    if (req0 && req1) winner = ~last_winner;
    else              winner = req0 ? PORT_CPU : PORT_DBG;
`else
    winner = req0 ? PORT_CPU : PORT_DBG;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between a CPU port and a debug/DMA port, one access per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; the default build uses fixed CPU priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              d_we,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_datain,
  input  logic [DATA_W-1:0] d_dataout
);

  state_t state, state_next;
  logic   owner;
  logic   op_we;
  logic   grant_valid;
  logic   winner;

`ifdef DMEM_ARB_RR_EN
  logic   last_winner;
`endif

  dmem_arb_select u_select (
    .req0        (req0),
    .req1        (req1),
`ifdef DMEM_ARB_RR_EN
    .last_winner (last_winner),
`endif
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  // NOTE: every register here uses <= so all of them see pre-edge values of state and inputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      d_we     <= 1'b0;
      d_addr   <= '0;
      d_datain <= '0;
      owner    <= PORT_CPU;
      op_we    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_winner <= PORT_DBG;
`endif
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            d_addr   <= (winner == PORT_DBG) ? addr1  : addr0;
            d_datain <= (winner == PORT_DBG) ? wdata1 : wdata0;
            d_we     <= (winner == PORT_DBG) ? we1    : we0;
            op_we    <= (winner == PORT_DBG) ? we1    : we0;
            owner    <= winner;
`ifdef DMEM_ARB_RR_EN
            last_winner <= winner;
`endif
          end else begin
            d_we <= 1'b0;
          end
        end
        // The memory commits the write at the end of ACCESS, so the strobe lasts one cycle.
        default: d_we <= 1'b0;
      endcase
    end
  end

  // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latches).
  always_comb begin
    state_next = ST_IDLE;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rdata      = '0;
    case (state)
      ST_IDLE:   state_next = grant_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE: begin
        state_next = ST_IDLE;
        ack0       = (owner == PORT_CPU);
        ack1       = (owner == PORT_DBG);
        // Read data registered by the memory at the end of ACCESS is passed straight through.
        if (!op_we) rdata = d_dataout;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected acks, a negedge monitor checks them.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_datain;
  logic [15:0] d_dataout;

  typedef struct {
    logic        port;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ack_count = 0;
  int          we_cycles = 0;
  int          ack_cyc[$];
  logic [15:0] mem [256];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_datain  (d_datain),
    .d_dataout (d_dataout)
  );

  always #5 clock = ~clock;

  // Memory model: no reset, write and registered read on the rising edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'hFF] = 16'h1234;
    d_dataout  = 16'h0000;
    forever begin
      @(posedge clock);
      if (d_we) mem[d_addr] <= d_datain;
      d_dataout <= mem[d_addr];
    end
  end

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (d_we) we_cycles++;
    if (ack0 || ack1) begin
      check("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
      ack_cyc.push_back(cyc);
      ack_count++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
        check("rdata", {16'd0, rdata}, {16'd0, e.data});
      end
    end
  end

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (ack_count < target && n < 30) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("ack_timeout", {31'd0, ack_count >= target}, 32'd1);
  endtask

  task automatic push(input logic port, input logic [15:0] data);
    exp_t x;
    x.port = port;
    x.data = data;
    sb.push_back(x);
  endtask

  initial begin
    int w;
    int base;
    int idx;

    // Reset held with both requests active.
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'hFF; wdata0 = 16'h0; wdata1 = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_d_we", {31'd0, d_we}, 32'd0);
    check("rst_d_addr", {24'd0, d_addr}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    next_edge();
    push(1'b0, 16'h0000);
    push(1'b1, 16'h1234);
    reset_n = 1'b1;
    wait_acks(1);
    next_edge();
    req0 = 1'b0;
    wait_acks(2);
    next_edge();
    req1 = 1'b0;

    // Port 0 write then read back.
    w = we_cycles;
    push(1'b0, 16'h0000);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h3C; wdata0 = 16'hBEEF;
    wait_acks(3);
    next_edge();
    req0 = 1'b0; we0 = 1'b0;
    check("we_pulse_len", we_cycles - w, 32'd1);
    check("mem_3c", {16'd0, mem[8'h3C]}, {16'd0, 16'hBEEF});
    push(1'b0, 16'hBEEF);
    req0 = 1'b1;
    wait_acks(4);
    next_edge();
    req0 = 1'b0;

    // Contention with both ports held. last_winner is 0 here, so round-robin starts with port 1.
    idx = ack_cyc.size();
`ifdef DMEM_ARB_RR_EN
    push(1'b1, 16'h1234); push(1'b0, 16'hBEEF);
    push(1'b1, 16'h1234); push(1'b0, 16'hBEEF);
`else
    for (int i = 0; i < 4; i++) push(1'b0, 16'hBEEF);
`endif
    req0 = 1'b1; addr0 = 8'h3C; req1 = 1'b1; addr1 = 8'hFF; we1 = 1'b0;
    wait_acks(8);
    next_edge();
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 1; i < 4; i++)
      if (ack_cyc.size() > idx + i)
        check("contention_spacing", ack_cyc[idx+i] - ack_cyc[idx+i-1], 32'd3);

    // Reset during ACCESS: write still lands, no ack.
    base = ack_count;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'hAAAA;
    next_edge();
    reset_n = 1'b0;
    next_edge();
    req1 = 1'b0; we1 = 1'b0;
    next_edge();
    reset_n = 1'b1;
    repeat (4) next_edge();
    check("rst_access_no_ack", ack_count, base);
    check("rst_access_mem", {16'd0, mem[8'h10]}, {16'd0, 16'hAAAA});

    // Reset at the grant edge: no strobe, memory unchanged.
    w = we_cycles;
    reset_n = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'h5555;
    next_edge();
    next_edge();
    req1 = 1'b0; we1 = 1'b0; reset_n = 1'b1;
    repeat (4) next_edge();
    check("rst_idle_no_ack", ack_count, base);
    check("rst_idle_no_we", we_cycles - w, 32'd0);
    check("rst_idle_mem", {16'd0, mem[8'h10]}, {16'd0, 16'hAAAA});

    // Late request from port 1 while port 0 is in ACCESS.
    push(1'b0, 16'hBEEF);
    push(1'b1, 16'hAAAA);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
    next_edge();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    wait_acks(base + 1);
    next_edge();
    req0 = 1'b0;
    wait_acks(base + 2);
    next_edge();
    req1 = 1'b0;
    if (ack_cyc.size() >= 2)
      check("late_req_spacing", ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2], 32'd3);

    repeat (4) next_edge();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
